// File: rtl/fmul_s3.sv
`default_nettype none
// ============================================================================
// fmul_s3 : FP multiplier final stage - normalize, IEEE round, pack, flags
// Revision 1.0
// ============================================================================
module fmul_s3 #(
  parameter int EXPWIDTH  = 8,
  parameter int PRECISION = 24,
  parameter int CTRLW     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_special_case_valid_i,
  input  logic                          in_special_case_nan_i,
  input  logic                          in_special_case_inf_i,
  input  logic                          in_special_case_inv_i,
  input  logic                          in_special_case_haszero_i,
  input  logic                          in_earyl_overflow_i,
  input  logic                          in_prod_sign_i,
  input  logic [EXPWIDTH:0]             in_shift_amt_i,
  input  logic [EXPWIDTH:0]             in_exp_shifted_i,
  input  logic                          in_may_be_subnormal_i,
  input  logic [2:0]                    in_rm_i,
  input  logic [2*PRECISION-1:0]        in_prod_i,
  input  logic [CTRLW-1:0]              in_ctrl_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [EXPWIDTH+PRECISION-1:0] out_result_o,
  output logic [4:0]                    out_fflags_o,
  output logic [CTRLW-1:0]              out_ctrl_o
);

  localparam int c_w2p = 2 * PRECISION;
  localparam int c_wr  = EXPWIDTH + PRECISION;
  localparam logic [2:0] c_rm_rne = 3'd0;
  localparam logic [2:0] c_rm_rtz = 3'd1;
  localparam logic [2:0] c_rm_rdn = 3'd2;
  localparam logic [2:0] c_rm_rup = 3'd3;
  localparam logic [2:0] c_rm_rmm = 3'd4;
  localparam logic [EXPWIDTH:0] c_exp_sat = {1'b0, {EXPWIDTH{1'b1}}};

  // --------------------------------------------------------------------------
  // Handshake: each stage advances when its successor can take it
  // --------------------------------------------------------------------------
  logic a_valid_q, a_valid_d;
  logic b_valid_q, b_valid_d;
  logic adv_a, adv_b, accept;

  always_comb begin
    adv_b  = !b_valid_q || out_ready_i;
    adv_a  = !a_valid_q || adv_b;
    accept = in_valid_i && adv_a;
  end

  assign in_ready_o  = adv_a;

  // --------------------------------------------------------------------------
  // Stage A: normalize the raw product
  // --------------------------------------------------------------------------
  logic [c_w2p-1:0]  sh;
  logic              top;
  logic              sub;
  logic [c_w2p-2:0]  norm_sig;
  logic [EXPWIDTH:0] norm_exp;
  logic [2:0]        rm_eff;

  always_comb begin
    sh  = in_prod_i << in_shift_amt_i;
    top = sh[c_w2p-1];
    sub = in_may_be_subnormal_i && !top;
    // the hidden bit is dropped here; a subnormal keeps its position unshifted
    if (top || sub) begin
      norm_sig = sh[c_w2p-2:0];
    end else begin
      norm_sig = {sh[c_w2p-3:0], 1'b0};
    end
    if (sub) begin
      norm_exp = '0;
    end else if (top) begin
      norm_exp = in_exp_shifted_i;
    end else begin
      norm_exp = in_exp_shifted_i - {{EXPWIDTH{1'b0}}, 1'b1};
    end
    rm_eff = (in_rm_i > c_rm_rmm) ? c_rm_rne : in_rm_i;
  end

  logic              a_spc_q,  a_spc_d;
  logic              a_nan_q,  a_nan_d;
  logic              a_inf_q,  a_inf_d;
  logic              a_inv_q,  a_inv_d;
  logic              a_zero_q, a_zero_d;
  logic              a_eov_q,  a_eov_d;
  logic              a_sign_q, a_sign_d;
  logic [2:0]        a_rm_q,   a_rm_d;
  logic [EXPWIDTH:0] a_exp_q,  a_exp_d;
  logic [c_w2p-2:0]  a_sig_q,  a_sig_d;
  logic [CTRLW-1:0]  a_ctrl_q, a_ctrl_d;

  always_comb begin
    a_valid_d = adv_a ? in_valid_i : a_valid_q;
    a_spc_d   = a_spc_q;
    a_nan_d   = a_nan_q;
    a_inf_d   = a_inf_q;
    a_inv_d   = a_inv_q;
    a_zero_d  = a_zero_q;
    a_eov_d   = a_eov_q;
    a_sign_d  = a_sign_q;
    a_rm_d    = a_rm_q;
    a_exp_d   = a_exp_q;
    a_sig_d   = a_sig_q;
    a_ctrl_d  = a_ctrl_q;
    if (accept) begin
      a_spc_d  = in_special_case_valid_i;
      a_nan_d  = in_special_case_nan_i;
      a_inf_d  = in_special_case_inf_i;
      a_inv_d  = in_special_case_inv_i;
      a_zero_d = in_special_case_haszero_i;
      a_eov_d  = in_earyl_overflow_i;
      a_sign_d = in_prod_sign_i;
      a_rm_d   = rm_eff;
      a_exp_d  = norm_exp;
      a_sig_d  = norm_sig;
      a_ctrl_d = in_ctrl_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stage B: round, detect overflow, resolve special cases
  // --------------------------------------------------------------------------
  logic [PRECISION-2:0]      frac;
  logic                      g, st, inc;
  logic                      of, nx, uf, ovf_inf;
  logic [c_wr-2:0]           rounded;
  logic [c_wr-1:0]           res_n;
  logic [4:0]                flags_n;

  always_comb begin
    frac = a_sig_q[c_w2p-2:PRECISION];
    g    = a_sig_q[PRECISION-1];
    st   = |a_sig_q[PRECISION-2:0];
    case (a_rm_q)
      c_rm_rne: inc = g && (st || frac[0]);
      c_rm_rtz: inc = 1'b0;
      c_rm_rdn: inc = a_sign_q && (g || st);
      c_rm_rup: inc = !a_sign_q && (g || st);
      c_rm_rmm: inc = g;
      default:  inc = g && (st || frac[0]);
    endcase
    // a fraction carry ripples into the exponent field
    rounded = {a_exp_q[EXPWIDTH-1:0], frac} + {{(c_wr-2){1'b0}}, inc};
    of      = a_eov_q || (a_exp_q >= c_exp_sat) || (&rounded[c_wr-2:PRECISION-1]);
    nx      = g || st || of;
    uf      = nx && (a_exp_q == '0);
    ovf_inf = (a_rm_q == c_rm_rne) || (a_rm_q == c_rm_rmm) ||
              ((a_rm_q == c_rm_rup) && !a_sign_q) ||
              ((a_rm_q == c_rm_rdn) && a_sign_q);

    if (of && ovf_inf) begin
      res_n = {a_sign_q, {EXPWIDTH{1'b1}}, {(PRECISION-1){1'b0}}};
    end else if (of) begin
      res_n = {a_sign_q, {(EXPWIDTH-1){1'b1}}, 1'b0, {(PRECISION-1){1'b1}}};
    end else begin
      res_n = {a_sign_q, rounded};
    end
    flags_n = {1'b0, 1'b0, of, uf, nx};

    if (a_spc_q && a_nan_q) begin
      res_n   = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(PRECISION-2){1'b0}}};
      flags_n = {a_inv_q, 4'b0000};
    end else if (a_spc_q && a_inf_q) begin
      res_n   = {a_sign_q, {EXPWIDTH{1'b1}}, {(PRECISION-1){1'b0}}};
      flags_n = 5'b00000;
    end else if (a_spc_q && a_zero_q) begin
      res_n   = {a_sign_q, {(c_wr-1){1'b0}}};
      flags_n = 5'b00000;
    end
  end

  logic [c_wr-1:0]  res_q,    res_d;
  logic [4:0]       fflags_q, fflags_d;
  logic [CTRLW-1:0] ctrl_q,   ctrl_d;

  always_comb begin
    b_valid_d = adv_b ? a_valid_q : b_valid_q;
    res_d     = res_q;
    fflags_d  = fflags_q;
    ctrl_d    = ctrl_q;
    if (adv_b && a_valid_q) begin
      res_d    = res_n;
      fflags_d = flags_n;
      ctrl_d   = a_ctrl_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_spc_q   <= 1'b0;
      a_nan_q   <= 1'b0;
      a_inf_q   <= 1'b0;
      a_inv_q   <= 1'b0;
      a_zero_q  <= 1'b0;
      a_eov_q   <= 1'b0;
      a_sign_q  <= 1'b0;
      a_rm_q    <= '0;
      a_exp_q   <= '0;
      a_sig_q   <= '0;
      a_ctrl_q  <= '0;
      b_valid_q <= 1'b0;
      res_q     <= '0;
      fflags_q  <= '0;
      ctrl_q    <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_spc_q   <= a_spc_d;
      a_nan_q   <= a_nan_d;
      a_inf_q   <= a_inf_d;
      a_inv_q   <= a_inv_d;
      a_zero_q  <= a_zero_d;
      a_eov_q   <= a_eov_d;
      a_sign_q  <= a_sign_d;
      a_rm_q    <= a_rm_d;
      a_exp_q   <= a_exp_d;
      a_sig_q   <= a_sig_d;
      a_ctrl_q  <= a_ctrl_d;
      b_valid_q <= b_valid_d;
      res_q     <= res_d;
      fflags_q  <= fflags_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign out_valid_o  = b_valid_q;
  assign out_result_o = res_q;
  assign out_fflags_o = fflags_q;
  assign out_ctrl_o   = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul_s3.sv
`default_nettype none
// ============================================================================
// tb_fmul_s3 : directed and randomized checks of fmul_s3 against an IEEE model
// Revision 1.0
// ============================================================================
module tb_fmul_s3;

  typedef struct packed {
    logic        scv;
    logic        nan;
    logic        inf;
    logic        inv;
    logic        hz;
    logic        eov;
    logic        sign;
    logic [8:0]  shamt;
    logic [8:0]  exps;
    logic        msub;
    logic [2:0]  rm;
    logic [47:0] prod;
    logic [7:0]  ctrl;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  bundle_t     cur;
  logic        in_valid_i;
  logic        out_ready_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_result_o;
  logic [4:0]  out_fflags_o;
  logic [7:0]  out_ctrl_o;

  int checks = 0;
  int errors = 0;
  logic [44:0] exp_q[$];

  always #5 clk = ~clk;

  fmul_s3 #(.EXPWIDTH(8), .PRECISION(24), .CTRLW(8)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .in_valid_i                (in_valid_i),
    .in_ready_o                (in_ready_o),
    .in_special_case_valid_i   (cur.scv),
    .in_special_case_nan_i     (cur.nan),
    .in_special_case_inf_i     (cur.inf),
    .in_special_case_inv_i     (cur.inv),
    .in_special_case_haszero_i (cur.hz),
    .in_earyl_overflow_i       (cur.eov),
    .in_prod_sign_i            (cur.sign),
    .in_shift_amt_i            (cur.shamt),
    .in_exp_shifted_i          (cur.exps),
    .in_may_be_subnormal_i     (cur.msub),
    .in_rm_i                   (cur.rm),
    .in_prod_i                 (cur.prod),
    .in_ctrl_i                 (cur.ctrl),
    .out_valid_o               (out_valid_o),
    .out_ready_i               (out_ready_i),
    .out_result_o              (out_result_o),
    .out_fflags_o              (out_fflags_o),
    .out_ctrl_o                (out_ctrl_o)
  );

  // Reference: returns {ctrl, result, fflags} using integer arithmetic
  function automatic logic [44:0] model(input bundle_t b);
    logic [47:0] sh, sig;
    logic        top, sub, g, st, inc, of, nx, uf, to_inf;
    logic [22:0] frac, f;
    logic [7:0]  e;
    int          ep, rm;
    longint      v;
    logic [31:0] res;
    logic [4:0]  fl;
    sh  = b.prod << b.shamt;
    top = sh[47];
    sub = b.msub && !top;
    sig = (top || sub) ? sh : (sh << 1);
    ep  = sub ? 0 : (top ? int'(b.exps) : int'(b.exps) - 1);
    frac = sig[46:24];
    g    = sig[23];
    st   = (sig[22:0] != 23'd0);
    rm   = (b.rm > 3'd4) ? 0 : int'(b.rm);
    case (rm)
      0:       inc = g && (st || frac[0]);
      1:       inc = 1'b0;
      2:       inc = b.sign && (g || st);
      3:       inc = !b.sign && (g || st);
      default: inc = g;
    endcase
    v  = longint'(ep & 255) * 64'd8388608 + longint'(frac) + (inc ? 64'd1 : 64'd0);
    e  = 8'((v >> 23) & 64'd255);
    f  = 23'(v & 64'h7FFFFF);
    of = b.eov || (ep >= 255) || (e == 8'hFF);
    nx = g || st || of;
    uf = nx && (ep == 0);
    to_inf = (rm == 0) || (rm == 4) || (rm == 3 && !b.sign) || (rm == 2 && b.sign);
    if (of) res = to_inf ? {b.sign, 8'hFF, 23'h0} : {b.sign, 8'hFE, 23'h7FFFFF};
    else    res = {b.sign, e, f};
    fl = {2'b00, of, uf, nx};
    if (b.scv && b.nan) begin
      res = 32'h7FC0_0000; fl = {b.inv, 4'b0000};
    end else if (b.scv && b.inf) begin
      res = {b.sign, 8'hFF, 23'h0}; fl = 5'b0;
    end else if (b.scv && b.hz) begin
      res = {b.sign, 31'h0}; fl = 5'b0;
    end
    return {b.ctrl, res, fl};
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t     b;
    logic [63:0] r;
    r       = {$urandom(), $urandom()};
    b.prod  = r[47:0] >> $urandom_range(0, 30);
    b.shamt = 9'($urandom_range(0, 34));
    b.exps  = 9'($urandom_range(1, 260));
    b.msub  = ($urandom_range(0, 3) == 0);
    b.rm    = 3'($urandom_range(0, 7));
    b.eov   = ($urandom_range(0, 15) == 0);
    b.scv   = ($urandom_range(0, 7) == 0);
    b.nan   = 1'($urandom_range(0, 1));
    b.inf   = 1'($urandom_range(0, 1));
    b.inv   = 1'($urandom_range(0, 1));
    b.hz    = 1'($urandom_range(0, 1));
    b.sign  = 1'($urandom_range(0, 1));
    b.ctrl  = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // scoreboard bookkeeping on the clock edge
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid_o && out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid_i && in_ready_o) exp_q.push_back(model(cur));
    end
  end

  // every cycle with a valid output is compared against the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %h required none", {out_ctrl_o, out_result_o, out_fflags_o});
      end else begin
        chk("stream", {out_ctrl_o, out_result_o, out_fflags_o}, exp_q[0]);
      end
    end
  end

  task automatic send(input bundle_t b);
    @(negedge clk);
    cur        = b;
    in_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready_o) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready 0 required 1");
  endtask

  task automatic directed(input string name, input bundle_t b, input logic [36:0] lit);
    logic [44:0] want;
    want = {b.ctrl, lit};
    chk({"model_", name}, model(b), want);
    send(b);
    @(negedge clk);
    in_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_o) break;
      @(negedge clk);
    end
    chk(name, {out_valid_o, out_ctrl_o, out_result_o, out_fflags_o}, {1'b1, want});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    bundle_t b;
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    cur         = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid_o, out_result_o, out_fflags_o, out_ctrl_o}, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", in_ready_o, 1);

    // 1.5 x 2.0 with latency check
    b = '0; b.prod = 48'h6000_0000_0000; b.exps = 9'd129; b.ctrl = 8'h11;
    chk("model_mul_1p5x2", model(b), {8'h11, 32'h4040_0000, 5'b00000});
    send(b);
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("latency_edge1", out_valid_o, 0);
    @(negedge clk);
    chk("latency_edge2", {out_valid_o, out_result_o, out_fflags_o}, {1'b1, 32'h4040_0000, 5'b00000});

    b = '0; b.prod = 48'h8000_0080_0000; b.exps = 9'd127; b.ctrl = 8'h12;
    directed("rne_tie_even", b, {32'h3F80_0000, 5'b00001});
    b.prod = 48'h8000_0180_0000; b.ctrl = 8'h13;
    directed("rne_tie_odd", b, {32'h3F80_0002, 5'b00001});

    b = '0; b.prod = 48'h6000_0000_0000; b.exps = 9'd129; b.eov = 1'b1; b.ctrl = 8'h14;
    directed("ovf_rne", b, {32'h7F80_0000, 5'b00101});
    b.rm = 3'd1; b.ctrl = 8'h15;
    directed("ovf_rtz", b, {32'h7F7F_FFFF, 5'b00101});

    b = '0; b.scv = 1'b1; b.nan = 1'b1; b.inv = 1'b1; b.ctrl = 8'h16;
    directed("nan_inv", b, {32'h7FC0_0000, 5'b10000});
    b = '0; b.scv = 1'b1; b.hz = 1'b1; b.sign = 1'b1; b.ctrl = 8'h17;
    directed("neg_zero", b, {32'h8000_0000, 5'b00000});

    b = '0; b.msub = 1'b1; b.exps = 9'd1; b.prod = 48'h0000_00C0_0000; b.ctrl = 8'h18;
    directed("subnormal", b, {32'h0000_0001, 5'b00011});
    b.prod = 48'h7FFF_FF80_0000; b.ctrl = 8'h19;
    directed("sub_to_normal", b, {32'h0080_0000, 5'b00011});

    // backpressure: two bundles fill the pipe while the sink stalls
    wait_drain("drain_directed");
    out_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b = rand_bundle(); b.ctrl = 8'hA0 + 8'(k);
      send(b);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    chk("bp_ready_low", in_ready_o, 0);
    @(negedge clk);
    out_ready_i = 1'b1;
    for (int k = 2; k < 4; k++) begin
      b = rand_bundle(); b.ctrl = 8'hA0 + 8'(k);
      send(b);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    wait_drain("drain_backpressure");

    // reset while the pipe is full
    out_ready_i = 1'b0;
    send(rand_bundle());
    send(rand_bundle());
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    in_valid_i = 1'b0;
    exp_q.delete();
    chk("reset_midstream", {out_valid_o, out_result_o, out_fflags_o, out_ctrl_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_midreset", in_ready_o, 1);
    out_ready_i = 1'b1;

    // randomized traffic with random stalls
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      cur         = rand_bundle();
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    wait_drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
